// File: rtl/wbu_regfile_if.sv
// rtl/wbu_regfile_if.sv - write-back bundle, decode read ports and halt status of wbu_regfile
interface wbu_regfile_if #(
    parameter int XLEN = 64
);
    logic            mmu_valid;
    logic [4:0]      mmu_index_rd;
    logic            mmu_wb_en;
    logic [XLEN-1:0] mmu_wb_data;
    logic            mmu_ebreak;
    logic [4:0]      idu_index_rs1;
    logic [4:0]      idu_index_rs2;
    logic [XLEN-1:0] gpr_data1;
    logic [XLEN-1:0] gpr_data2;
    logic            wbu_halt;
    logic [XLEN-1:0] wbu_exit_code;
    logic [63:0]     wbu_retired;
    logic [1:0]      wbu_state;

    modport master (
        output mmu_valid, mmu_index_rd, mmu_wb_en, mmu_wb_data, mmu_ebreak,
        output idu_index_rs1, idu_index_rs2,
        input  gpr_data1, gpr_data2, wbu_halt, wbu_exit_code, wbu_retired, wbu_state
    );

    modport slave (
        input  mmu_valid, mmu_index_rd, mmu_wb_en, mmu_wb_data, mmu_ebreak,
        input  idu_index_rs1, idu_index_rs2,
        output gpr_data1, gpr_data2, wbu_halt, wbu_exit_code, wbu_retired, wbu_state
    );
endinterface

// File: rtl/wbu_regfile.sv
// rtl/wbu_regfile.sv - write-back stage, 32-entry GPR file with bypassed reads and ebreak halt sequencer
module wbu_regfile #(
    parameter int          XLEN          = 64,
    parameter int          DRAIN_CYCLES  = 2,
    parameter logic [63:0] RETIRED_RESET = 64'd0
) (
    input  logic          clk,
    input  logic          rstn,
    wbu_regfile_if.slave  bus
);
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [XLEN-1:0] r_gpr [32];
    logic [1:0]      r_state;
    logic [3:0]      r_drain_cnt;
    logic            r_halt;
    logic [XLEN-1:0] r_exit_code;
    logic [63:0]     r_retired;

    logic w_run;
    logic w_retire;
    logic w_commit;

    assign w_run    = (r_state == ST_RUN);
    assign w_retire = w_run && bus.mmu_valid;
    assign w_commit = w_retire && bus.mmu_wb_en && (bus.mmu_index_rd != 5'd0);

    // Entry 0 is reset and never written, but reads of x0 are still forced to zero explicitly
    assign bus.gpr_data1 = (bus.idu_index_rs1 == 5'd0) ? '0 :
                           (w_commit && bus.idu_index_rs1 == bus.mmu_index_rd) ? bus.mmu_wb_data :
                           r_gpr[bus.idu_index_rs1];
    assign bus.gpr_data2 = (bus.idu_index_rs2 == 5'd0) ? '0 :
                           (w_commit && bus.idu_index_rs2 == bus.mmu_index_rd) ? bus.mmu_wb_data :
                           r_gpr[bus.idu_index_rs2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_commit) begin
            r_gpr[bus.mmu_index_rd] <= bus.mmu_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_retired <= RETIRED_RESET;
        end else if (w_retire) begin
            r_retired <= r_retired + 64'd1;
        end
    end

    // x10 is sampled from the array at the last DRAIN edge, so an ebreak that writes a0 is already visible
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 4'd0;
            r_halt      <= 1'b0;
            r_exit_code <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.mmu_valid && bus.mmu_ebreak) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == 4'd0) begin
                        r_state     <= ST_HALTED;
                        r_halt      <= 1'b1;
                        r_exit_code <= r_gpr[10];
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 4'd1;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.wbu_halt      = r_halt;
    assign bus.wbu_exit_code = r_exit_code;
    assign bus.wbu_retired   = r_retired;
    assign bus.wbu_state     = r_state;
endmodule
